// File: rtl/sram_arbiter.sv
// Two-requester arbiter for a single-port synchronous SRAM. A round-robin
// priority pointer settles contention; reads return data the cycle after acceptance.
module sram_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_0,
  input  logic              req_we_0,
  input  logic [ADDR_W-1:0] req_addr_0,
  input  logic [DATA_W-1:0] req_wdata_0,
  output logic              req_ready_0,
  output logic              rsp_valid_0,
  output logic [DATA_W-1:0] rsp_rdata_0,
  input  logic              req_valid_1,
  input  logic              req_we_1,
  input  logic [ADDR_W-1:0] req_addr_1,
  input  logic [DATA_W-1:0] req_wdata_1,
  output logic              req_ready_1,
  output logic              rsp_valid_1,
  output logic [DATA_W-1:0] rsp_rdata_1,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [7:0]        grant_cnt_0,
  output logic [7:0]        grant_cnt_1,
  output logic              prio_state
);

  // Handshake: a request is accepted on a rising edge where req_valid_x and
  // req_ready_x are both high; ready depends combinationally on valid and prio.
  typedef enum logic {PRIO0 = 1'b0, PRIO1 = 1'b1} prio_t;

  prio_t prio;
  logic  win_0, win_1;
  logic  rsp_pend_0, rsp_pend_1;

  // Reset gating keeps the arbiter silent while rst_n is low.
  always_comb begin
    win_0 = rst_n & req_valid_0 & (~req_valid_1 | (prio == PRIO0));
    win_1 = rst_n & req_valid_1 & (~req_valid_0 | (prio == PRIO1));
  end

  assign req_ready_0 = win_0;
  assign req_ready_1 = win_1;
  assign prio_state  = prio;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (win_0) begin
      mem_we    = req_we_0;
      mem_addr  = req_addr_0;
      mem_wdata = req_wdata_0;
    end else if (win_1) begin
      mem_we    = req_we_1;
      mem_addr  = req_addr_1;
      mem_wdata = req_wdata_1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio <= PRIO0;
    end else begin
      case (prio)
        PRIO0:   if (win_0) prio <= PRIO1;
        PRIO1:   if (win_1) prio <= PRIO0;
        default: prio <= PRIO0;
      endcase
    end
  end

  // The SRAM registers its output on the acceptance edge, so mem_rdata is
  // valid during the cycle after a read is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_pend_0 <= 1'b0;
      rsp_pend_1 <= 1'b0;
    end else begin
      rsp_pend_0 <= win_0 & ~req_we_0;
      rsp_pend_1 <= win_1 & ~req_we_1;
    end
  end

  assign rsp_valid_0 = rsp_pend_0;
  assign rsp_valid_1 = rsp_pend_1;
  assign rsp_rdata_0 = rsp_pend_0 ? mem_rdata : '0;
  assign rsp_rdata_1 = rsp_pend_1 ? mem_rdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt_0 <= 8'h00;
      grant_cnt_1 <= 8'h00;
    end else begin
      if (win_0 && grant_cnt_0 != 8'hFF) grant_cnt_0 <= grant_cnt_0 + 8'd1;
      if (win_1 && grant_cnt_1 != 8'hFF) grant_cnt_1 <= grant_cnt_1 + 8'd1;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural synchronous SRAM model
// (registered read, memory preloaded with addr ^ 8'h5A).
module tb_sram_arbiter;

  logic       clk, rst_n;
  logic       req_valid_0, req_we_0, req_valid_1, req_we_1;
  logic [7:0] req_addr_0, req_wdata_0, req_addr_1, req_wdata_1;
  logic       req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1;
  logic [7:0] rsp_rdata_0, rsp_rdata_1;
  logic       mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0] grant_cnt_0, grant_cnt_1;
  logic       prio_state;
  logic [7:0] mem [256];
  int         n_cmp, n_bad;

  sram_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_0(req_valid_0), .req_we_0(req_we_0), .req_addr_0(req_addr_0),
    .req_wdata_0(req_wdata_0), .req_ready_0(req_ready_0),
    .rsp_valid_0(rsp_valid_0), .rsp_rdata_0(rsp_rdata_0),
    .req_valid_1(req_valid_1), .req_we_1(req_we_1), .req_addr_1(req_addr_1),
    .req_wdata_1(req_wdata_1), .req_ready_1(req_ready_1),
    .rsp_valid_1(rsp_valid_1), .rsp_rdata_1(rsp_rdata_1),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .grant_cnt_0(grant_cnt_0), .grant_cnt_1(grant_cnt_1),
    .prio_state(prio_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
  end

  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr];
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid_0 = 1'b0; req_we_0 = 1'b0; req_addr_0 = 8'h00; req_wdata_0 = 8'h00;
    req_valid_1 = 1'b0; req_we_1 = 1'b0; req_addr_1 = 8'h00; req_wdata_1 = 8'h00;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    req_valid_0 = 1'b1; req_valid_1 = 1'b1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (req_ready_0 !== 1'b0) begin n_bad++; $display("FAIL reset_ready0 got %b want 0", req_ready_0); end
    n_cmp++; if (req_ready_1 !== 1'b0) begin n_bad++; $display("FAIL reset_ready1 got %b want 0", req_ready_1); end
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
    n_cmp++; if (rsp_valid_0 !== 1'b0 || rsp_valid_1 !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid got %b%b want 00", rsp_valid_0, rsp_valid_1); end
    n_cmp++; if (grant_cnt_0 !== 8'h00 || grant_cnt_1 !== 8'h00) begin n_bad++; $display("FAIL reset_cnt got %h/%h want 00/00", grant_cnt_0, grant_cnt_1); end
    n_cmp++; if (prio_state !== 1'b0) begin n_bad++; $display("FAIL reset_prio got %b want 0", prio_state); end
    tick();
    n_cmp++; if (grant_cnt_0 !== 8'h00) begin n_bad++; $display("FAIL reset_ignore_req got %h want 00", grant_cnt_0); end
    idle();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    req_valid_0 = 1'b1; req_we_0 = 1'b1; req_addr_0 = 8'h0A; req_wdata_0 = 8'hF0;
    #1;
    n_cmp++; if (req_ready_0 !== 1'b1 || req_ready_1 !== 1'b0) begin n_bad++; $display("FAIL wr_ready got %b%b want 10", req_ready_0, req_ready_1); end
    n_cmp++; if (mem_we !== 1'b1) begin n_bad++; $display("FAIL wr_mem_we got %b want 1", mem_we); end
    n_cmp++; if (mem_addr !== 8'h0A) begin n_bad++; $display("FAIL wr_mem_addr got %h want 0a", mem_addr); end
    n_cmp++; if (mem_wdata !== 8'hF0) begin n_bad++; $display("FAIL wr_mem_wdata got %h want f0", mem_wdata); end
    tick();
    req_we_0 = 1'b0;
    #1;
    n_cmp++; if (req_ready_0 !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'h0A) begin n_bad++; $display("FAIL rd_issue got rdy=%b we=%b addr=%h want 1/0/0a", req_ready_0, mem_we, mem_addr); end
    n_cmp++; if (rsp_valid_0 !== 1'b0) begin n_bad++; $display("FAIL wr_no_rsp got %b want 0", rsp_valid_0); end
    tick();
    idle();
    #1;
    n_cmp++; if (rsp_valid_0 !== 1'b1) begin n_bad++; $display("FAIL rd_rsp_valid got %b want 1", rsp_valid_0); end
    n_cmp++; if (rsp_rdata_0 !== 8'hF0) begin n_bad++; $display("FAIL rd_rsp_data got %h want f0", rsp_rdata_0); end
    n_cmp++; if (rsp_valid_1 !== 1'b0) begin n_bad++; $display("FAIL rd_rsp_valid1 got %b want 0", rsp_valid_1); end
    n_cmp++; if (mem_we !== 1'b0 || mem_addr !== 8'h00 || mem_wdata !== 8'h00) begin n_bad++; $display("FAIL idle_mem got we=%b addr=%h wd=%h want 0/00/00", mem_we, mem_addr, mem_wdata); end
    n_cmp++; if (grant_cnt_0 !== 8'h02) begin n_bad++; $display("FAIL wr_rd_cnt got %h want 02", grant_cnt_0); end
    n_cmp++; if (prio_state !== 1'b1) begin n_bad++; $display("FAIL wr_rd_prio got %b want 1", prio_state); end
    tick();
    n_cmp++; if (rsp_valid_0 !== 1'b0 || rsp_rdata_0 !== 8'h00) begin n_bad++; $display("FAIL rsp_one_cycle got %b/%h want 0/00", rsp_valid_0, rsp_rdata_0); end
  endtask

  task automatic test_back_to_back();
    bit odd;
    pulse_reset();
    req_valid_0 = 1'b1; req_addr_0 = 8'h1F;
    req_valid_1 = 1'b1; req_addr_1 = 8'h20;
    #1;
    for (int i = 0; i < 4; i++) begin
      odd = (i % 2) == 1;
      n_cmp++; if (req_ready_0 !== !odd || req_ready_1 !== odd) begin n_bad++; $display("FAIL alt_grant[%0d] got %b%b want %b%b", i, req_ready_0, req_ready_1, !odd, odd); end
      n_cmp++; if (rsp_valid_0 !== odd || rsp_rdata_0 !== (odd ? 8'h45 : 8'h00)) begin n_bad++; $display("FAIL alt_rsp0[%0d] got %b/%h want %b/%h", i, rsp_valid_0, rsp_rdata_0, odd, odd ? 8'h45 : 8'h00); end
      n_cmp++; if (rsp_valid_1 !== (i == 2) || rsp_rdata_1 !== ((i == 2) ? 8'h7A : 8'h00)) begin n_bad++; $display("FAIL alt_rsp1[%0d] got %b/%h want %b", i, rsp_valid_1, rsp_rdata_1, i == 2); end
      tick();
    end
    idle();
    #1;
    n_cmp++; if (rsp_valid_1 !== 1'b1 || rsp_rdata_1 !== 8'h7A) begin n_bad++; $display("FAIL alt_last_rsp1 got %b/%h want 1/7a", rsp_valid_1, rsp_rdata_1); end
    n_cmp++; if (grant_cnt_0 !== 8'h02 || grant_cnt_1 !== 8'h02) begin n_bad++; $display("FAIL alt_cnt got %h/%h want 02/02", grant_cnt_0, grant_cnt_1); end
    tick();
  endtask

  task automatic test_raw();
    req_valid_1 = 1'b1; req_we_1 = 1'b1; req_addr_1 = 8'h1F; req_wdata_1 = 8'h55;
    #1;
    n_cmp++; if (req_ready_1 !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 8'h55) begin n_bad++; $display("FAIL raw_write got rdy=%b we=%b wd=%h want 1/1/55", req_ready_1, mem_we, mem_wdata); end
    tick();
    idle();
    req_valid_0 = 1'b1; req_addr_0 = 8'h1F;
    #1;
    n_cmp++; if (req_ready_0 !== 1'b1) begin n_bad++; $display("FAIL raw_read_ready got %b want 1", req_ready_0); end
    tick();
    idle();
    #1;
    n_cmp++; if (rsp_valid_0 !== 1'b1 || rsp_rdata_0 !== 8'h55) begin n_bad++; $display("FAIL raw_data got %b/%h want 1/55", rsp_valid_0, rsp_rdata_0); end
    tick();
  endtask

  task automatic test_reset_drop();
    req_valid_0 = 1'b1; req_addr_0 = 8'h0A;
    #1;
    n_cmp++; if (req_ready_0 !== 1'b1) begin n_bad++; $display("FAIL drop_ready got %b want 1", req_ready_0); end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    req_valid_1 = 1'b1;
    #1;
    n_cmp++; if (rsp_valid_0 !== 1'b0 || rsp_rdata_0 !== 8'h00) begin n_bad++; $display("FAIL drop_rsp got %b/%h want 0/00", rsp_valid_0, rsp_rdata_0); end
    n_cmp++; if (grant_cnt_0 !== 8'h00) begin n_bad++; $display("FAIL drop_cnt got %h want 00", grant_cnt_0); end
    n_cmp++; if (prio_state !== 1'b0) begin n_bad++; $display("FAIL drop_prio got %b want 0", prio_state); end
    n_cmp++; if (req_ready_0 !== 1'b0 || req_ready_1 !== 1'b0) begin n_bad++; $display("FAIL drop_ready_rst got %b%b want 00", req_ready_0, req_ready_1); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++; if (rsp_valid_0 !== 1'b0) begin n_bad++; $display("FAIL drop_after_release got %b want 0", rsp_valid_0); end
    n_cmp++; if (req_ready_0 !== 1'b1 || req_ready_1 !== 1'b0) begin n_bad++; $display("FAIL post_reset_prio got %b%b want 10", req_ready_0, req_ready_1); end
    tick();
    n_cmp++; if (grant_cnt_0 !== 8'h01) begin n_bad++; $display("FAIL post_reset_cnt got %h want 01", grant_cnt_0); end
    idle();
    tick();
  endtask

  task automatic test_saturate();
    pulse_reset();
    req_valid_0 = 1'b1; req_we_0 = 1'b1; req_addr_0 = 8'h40;
    for (int i = 0; i < 300; i++) begin
      req_wdata_0 = 8'(i);
      #1;
      n_cmp++; if (req_ready_0 !== 1'b1 || req_ready_1 !== 1'b0) begin n_bad++; $display("FAIL sat_ready[%0d] got %b%b want 10", i, req_ready_0, req_ready_1); end
      tick();
      if (i == 199) begin
        n_cmp++; if (grant_cnt_0 !== 8'hC8) begin n_bad++; $display("FAIL sat_mid_cnt got %h want c8", grant_cnt_0); end
      end
    end
    idle();
    #1;
    n_cmp++; if (grant_cnt_0 !== 8'hFF) begin n_bad++; $display("FAIL sat_cnt got %h want ff", grant_cnt_0); end
    n_cmp++; if (grant_cnt_1 !== 8'h00) begin n_bad++; $display("FAIL sat_cnt1 got %h want 00", grant_cnt_1); end
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_raw();
    test_reset_drop();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, SRAM address width.
REQ-002 SHALL have parameter DATA_W, default 8, SRAM data width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have, for each requester x in {0,1}, port req_valid_x  input  1  request pending.
REQ-006 SHALL have port req_we_x  input  1  1 = write, 0 = read.
REQ-007 SHALL have port req_addr_x  input  ADDR_W  target address.
REQ-008 SHALL have port req_wdata_x  input  DATA_W  write data.
REQ-009 SHALL have port req_ready_x  output  1  request accepted this cycle.
REQ-010 SHALL have port rsp_valid_x  output  1  read data valid, one-cycle pulse.
REQ-011 SHALL have port rsp_rdata_x  output  DATA_W  read data.
REQ-012 SHALL have port mem_we  output  1  SRAM write enable.
REQ-013 SHALL have port mem_addr  output  ADDR_W  SRAM address.
REQ-014 SHALL have port mem_wdata  output  DATA_W  SRAM write data.
REQ-015 SHALL have port mem_rdata  input  DATA_W  SRAM data out; registered on the edge that samples mem_addr.
REQ-016 SHALL have port grant_cnt_x  output  8  saturating count of accepted requests per requester.

Function
REQ-017 SHALL accept at most one request per cycle; accepted = req_valid_x & req_ready_x before a rising edge.
REQ-018 SHALL assert req_ready_x combinationally, only for the winner, never for both.
REQ-019 Winner: sole valid requester; if both valid, the requester named by priority pointer prio.
REQ-020 prio SHALL be a 2-state FSM (PRIO0, PRIO1); after any acceptance it SHALL move to the non-winning requester; with no acceptance it SHALL hold.
REQ-021 In an accepting cycle, mem_addr/mem_we/mem_wdata SHALL combinationally equal the winner's req_addr/req_we/req_wdata.
REQ-022 In a non-accepting cycle, mem_we SHALL be 0; mem_addr and mem_wdata SHALL be 0.
REQ-023 Accepted read SHALL pulse rsp_valid_x for exactly the one cycle following the acceptance edge, with rsp_rdata_x = mem_rdata in that cycle.
REQ-024 rsp_rdata_x SHALL be 0 whenever rsp_valid_x is 0.
REQ-025 Accepted write SHALL produce no response; write data SHALL be in SRAM at the acceptance edge.
REQ-026 Back-to-back: read accepted at edge k and any request accepted at edge k+1 SHALL both be legal; response for k SHALL be delivered in cycle k+1 unaffected.
REQ-027 Read-after-write, same address, consecutive acceptances SHALL return the newly written data.
REQ-028 A requester holding req_valid SHALL be granted within 2 cycles (no starvation).
REQ-029 grant_cnt_x SHALL increment by 1 on each acceptance for x and saturate at 8'hFF.
REQ-030 Request inputs SHALL be ignored while rst_n = 0.

Reset
REQ-031 rst_n = 0 SHALL immediately force rsp_valid_x = 0, rsp_rdata_x = 0, grant_cnt_x = 0, prio = PRIO0, mem_we = 0, req_ready_x = 0.
REQ-032 Read accepted on the edge before reset assertion SHALL have its response dropped; no rsp_valid after release.
REQ-033 First cycle after rst_n release SHALL arbitrate normally, with requester 0 favoured on contention.

Verification
REQ-034 r0 write 0x0A=0xF0, then r0 read 0x0A -> rsp_valid_0 one cycle after read acceptance, rsp_rdata_0 = 0xF0; rsp_valid_1 stays 0.
REQ-035 Both valid continuously after reset, r0 read 0x1F, r1 read 0x20 -> grants alternate 0,1,0,1; each rsp_valid_x the cycle after its grant.
REQ-036 r1 write 0x1F=0x55 at edge k, r0 read 0x1F at edge k+1 -> rsp_rdata_0 = 0x55 in cycle k+2.
REQ-037 r0 read accepted, rst_n pulsed low mid-cycle before the response -> rsp_valid_0 never asserts; grant_cnt_0 = 0; next contention grants r0.
REQ-038 r0 valid for 300 consecutive cycles alone -> grant_cnt_0 = 0xFF, no wrap; req_ready_1 never asserted.
